// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract pipeline: data width, opcode
// encodings and small opcode decode helpers.
package addsub_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Subtracting ops feed ~b into the adder (carry means NOT borrow).
  function automatic logic op_inverts_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  function automatic logic op_uses_carry(input op_e op);
    return (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/addsub_pipe_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group
// generate/propagate chained between groups.
module addsub_pipe_cla (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    logic gg;
    logic pp;
    c    = '0;
    c[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp = &p[4*k +: 4];
      c[4*k+4] = gg | (pp & c[4*k]);
    end
  end

  assign S    = p ^ c[31:0];
  assign Cout = c[32];

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract pipeline (operand reg -> CLA adder -> result reg)
// with carry chaining for ADC/SBB. Define ADDSUB_PIPE_OVF_EN for out_v.
module addsub_pipe
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_c,
  output logic              out_z,
  output logic              out_n,
  output logic              out_v
);

  logic              s1_valid;
  op_e               s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_s;
  logic              s2_c;
  logic              s2_z;
  logic              s2_n;

  logic              s1_advance;
  logic              s1_load;
  logic [DATA_W-1:0] b_in;
  logic              cin;
  logic [DATA_W-1:0] sum;
  logic              cout;

  // Handshake: a beat moves when valid && ready on the same rising edge;
  // valid and payload are held unchanged by the producer until that happens.
  assign s1_advance = s1_valid && (!s2_valid || out_ready);
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign s1_load    = in_valid && in_ready;

  // s2_c doubles as the architectural carry flag: it is written on every
  // S1->S2 transfer, so a back-to-back ADC/SBB already sees its predecessor.
  always_comb begin
    b_in = s1_b;
    cin  = 1'b0;
    if (op_inverts_b(s1_op)) begin
      b_in = ~s1_b;
      cin  = 1'b1;
    end
    if (op_uses_carry(s1_op)) begin
      cin = s2_c;
    end
  end

  addsub_pipe_cla u_cla (
    .A    (s1_a),
    .B    (b_in),
    .Cin  (cin),
    .S    (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_c     <= 1'b0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_op <= op_e'(in_op);
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end

      if (s1_advance) begin
        s2_valid <= 1'b1;
        s2_s     <= sum;
        s2_c     <= cout;
        s2_z     <= (sum == '0);
        s2_n     <= sum[DATA_W-1];
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef ADDSUB_PIPE_OVF_EN
  logic s2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (s1_advance) begin
      s2_v <= (s1_a[DATA_W-1] == b_in[DATA_W-1]) && (sum[DATA_W-1] != s1_a[DATA_W-1]);
    end
  end

  assign out_v = s2_v;
`else
  assign out_v = 1'b0;
`endif

  assign out_valid = s2_valid;
  assign out_s     = s2_s;
  assign out_c     = s2_c;
  assign out_z     = s2_z;
  assign out_n     = s2_n;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: arithmetic, carry chaining, stall/hold,
// and reset-with-full-pipeline behaviour.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_c;
  logic        out_z;
  logic        out_n;
  logic        out_v;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ADDSUB_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_v     (out_v)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input string tag, input logic [31:0] s, input logic c,
                            input logic z, input logic n, input logic v);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_s"}, out_s, s);
    check({tag, "_c"}, {31'd0, out_c}, {31'd0, c});
    check({tag, "_z"}, {31'd0, out_z}, {31'd0, z});
    check({tag, "_n"}, {31'd0, out_n}, {31'd0, n});
    check({tag, "_v"}, {31'd0, out_v}, {31'd0, v});
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, OP_ADD, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    expect_idle("rst");
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_s", out_s, 32'h0);
    check("rst_flags", {28'd0, out_c, out_z, out_n, out_v}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD 3+4, latency 2
    drive(1'b1, OP_ADD, 32'h3, 32'h4);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_idle("add_lat1");
    tick();
    expect_res("add34", 32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_idle("add34_drain");

    // SUB 5-7 then SUB 7-5 back-to-back
    drive(1'b1, OP_SUB, 32'h5, 32'h7);
    tick();
    drive(1'b1, OP_SUB, 32'h7, 32'h5);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_res("sub57", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_res("sub75", 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_idle("sub_drain");

    // ADD 0xFFFFFFFF+1 then ADC 0+0, no stall
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b1, OP_ADC, 32'h0, 32'h0);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_res("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_res("adc_chain", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Signed overflow
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    tick();
    expect_res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, OVF_ON);
    tick();

    // Stall: out_ready low 5 cycles, 3 ops offered
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'h1, 32'h1);
    #1;
    check("stall_rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, OP_ADD, 32'h2, 32'h2);
    #1;
    check("stall_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, OP_ADD, 32'h3, 32'h3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rdy_held", {31'd0, in_ready}, 32'd0);
      expect_res("stall_hold", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_rdy", {31'd0, in_ready}, 32'd1);
    expect_res("release_op1", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_res("release_op2", 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_res("release_op3", 32'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_idle("release_drain");

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b1, OP_ADD, 32'h5, 32'h5);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_res("full_pre_rst", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    expect_idle("rst_mid");
    check("rst_mid_c", {31'd0, out_c}, 32'd0);
    check("rst_mid_s", out_s, 32'h0);
    drive(1'b1, OP_ADC, 32'h1, 32'h1);
    tick();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    expect_idle("adc_after_rst_lat1");
    tick();
    expect_res("adc_after_rst", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_idle("no_ghost");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have the port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port in_valid, input, 1 bit: the request on in_op, in_a and in_b is valid.
REQ-004 SHALL have the port in_ready, output, 1 bit: the stage accepts a request this cycle.
REQ-005 SHALL have the port in_op, input, 2 bits: opcode; ADD=00, SUB=01, ADC=10, SBB=11.
REQ-006 SHALL have the ports in_a and in_b, input, 32 bits each: operands.
REQ-007 SHALL have the port out_valid, output, 1 bit: result and flags are valid.
REQ-008 SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have the port out_s, output, 32 bits: sum or difference.
REQ-010 SHALL have the ports out_c, out_z, out_n and out_v, output, 1 bit each: carry, zero, negative and overflow flags of out_s.

Function
REQ-011 SHALL be a 2-stage pipeline: operand register S1, then the combinational 32-bit adder, then result register S2.
REQ-012 SHALL transfer a request into S1 on in_valid && in_ready.
REQ-013 SHALL transfer S1 to S2 when S1 is valid and (S2 is empty, or out_ready is high).
REQ-014 SHALL drive in_ready = !s1_valid || s1_advance, giving full throughput of 1 op/cycle with no bubble.
REQ-015 SHALL drive the adder from S1 as follows: the A input is a; the B input is b for ADD/ADC and ~b for SUB/SBB; Cin is 0 for ADD, 1 for SUB, and carry flag C for ADC/SBB.
REQ-016 SHALL update carry flag C with adder Cout on every S1->S2 transfer; C resets to 0.
REQ-017 SHALL give ADC/SBB the carry of the immediately preceding accepted op, even when issued back-to-back with no stall; ops move in order, so the predecessor has already updated C on its S1->S2 transfer.
REQ-018 SHALL use carry = NOT borrow for subtraction; example: SUB 5-7 gives C=0.
REQ-019 SHALL compute the flags as: out_z = (out_s == 0); out_n = out_s[31]; out_c = Cout; out_v = (a[31]==Bin[31]) && (s[31]!=a[31]), where Bin is the post-inversion B.
REQ-020 SHALL have a latency of exactly 2 cycles from request acceptance to out_valid when there are no stalls.
REQ-021 SHALL hold out_s, the flags and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, when S2 is stalled and S1 is full, deassert in_ready and hold both stages.
REQ-023 SHALL, on a simultaneous S2 drain and new accept, move S1 into S2 and load S1 in the same cycle.
REQ-024 SHALL wrap arithmetic mod 2^32; 0xFFFFFFFF+1 gives S=0, C=1, Z=1.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear s1_valid, s2_valid, out_valid and C, and zero out_s, out_c, out_z, out_n and out_v.
REQ-026 SHALL, while rst=1, force in_ready=0.
REQ-027 SHALL discard in-flight ops on a reset mid-operation, with no output produced for them.
REQ-028 SHALL have S1/S2 data registers zeroed by reset.

Configuration
REQ-029 SHALL, with macro ADDSUB_PIPE_OVF_EN defined, compute out_v per REQ-019 and register it in S2.
REQ-030 SHALL, without ADDSUB_PIPE_OVF_EN, tie out_v to 0, include no overflow logic, and leave all other behaviour unchanged.

Structure
REQ-031 SHALL take the opcode encodings ADD/SUB/ADC/SBB and the width constant DATA_W=32 from shared package addsub_pkg.
REQ-032 SHALL instantiate the team's existing 32-bit carry-lookahead adder as the sole sub-module, ports A, B, Cin, S and Cout.
REQ-033 SHALL contain no other arithmetic; the inversion, Cin select, flags and pipeline control are local logic.

Verification
REQ-034 SHALL cover: ADD 0x00000003+0x00000004 -> out_s=0x7, C=0, Z=0, out_valid 2 cycles after accept.
REQ-035 SHALL cover: SUB 5-7 -> out_s=0xFFFFFFFE, C=0, N=1; SUB 7-5 -> 0x2, C=1.
REQ-036 SHALL cover: back-to-back ADD 0xFFFFFFFF+1 then ADC 0+0 -> 0x0 (C=1, Z=1), then 0x1 (C=0).
REQ-037 SHALL cover: ADD 0x7FFFFFFF+1 -> 0x80000000, V=1 with ADDSUB_PIPE_OVF_EN and V=0 without it.
REQ-038 SHALL cover: out_ready=0 for 5 cycles with 3 ops offered -> 2 held (in_ready=0), result stable; release -> all 3 in order, none lost.
REQ-039 SHALL cover: rst pulsed with both stages full -> next cycle out_valid=0, C=0; the next ADC 1+1 -> 0x2.
